// File: rtl/square_plot_arbiter.sv
// Round-robin arbiter granting one of three requesters the VGA plot port and
// rastering an XDIM x YDIM filled square for the winner, one pixel per cycle.
module square_plot_arbiter #(
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [20:0] req_y,
    input  logic [8:0]  req_colour,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] XLAST = 4'(XDIM - 1);
    localparam logic [3:0] YLAST = 4'(YDIM - 1);
    localparam logic [8:0] XLIM  = 9'(XSCREEN);
    localparam logic [7:0] YLIM  = 8'(YSCREEN);

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next;
    logic [1:0] win, win_next;
    logic [2:0] grant_q, grant_next;
    logic [3:0] xc, xc_next;
    logic [3:0] yc, yc_next;
    logic [7:0] x0, x0_next;
    logic [6:0] y0, y0_next;
    logic [2:0] col, col_next;

    logic [1:0] sel;
    logic       sel_valid;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_col;

    logic [8:0] ux;
    logic [7:0] uy;

    // Search starts at ptr and wraps 2 -> 0; first set request wins.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] cand;
        sel       = '0;
        sel_valid = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            sum  = {1'b0, ptr} + 3'(k);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!sel_valid && req[cand]) begin
                sel       = cand;
                sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0: begin
                sel_x   = req_x[7:0];
                sel_y   = req_y[6:0];
                sel_col = req_colour[2:0];
            end
            2'd1: begin
                sel_x   = req_x[15:8];
                sel_y   = req_y[13:7];
                sel_col = req_colour[5:3];
            end
            default: begin
                sel_x   = req_x[23:16];
                sel_y   = req_y[20:14];
                sel_col = req_colour[8:6];
            end
        endcase
    end

    // Unwrapped pixel address feeds the on-screen test; low bits go to the port.
    assign ux = {1'b0, x0} + {5'b0, xc};
    assign uy = {1'b0, y0} + {4'b0, yc};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            grant_q <= '0;
            xc      <= '0;
            yc      <= '0;
            x0      <= '0;
            y0      <= '0;
            col     <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            win     <= win_next;
            grant_q <= grant_next;
            xc      <= xc_next;
            yc      <= yc_next;
            x0      <= x0_next;
            y0      <= y0_next;
            col     <= col_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        win_next   = win;
        grant_next = grant_q;
        xc_next    = xc;
        yc_next    = yc;
        x0_next    = x0;
        y0_next    = y0;
        col_next   = col;
        done       = '0;
        plot       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;

        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_next = FILL;
                    win_next   = sel;
                    grant_next = 3'b001 << sel;
                    x0_next    = sel_x;
                    y0_next    = sel_y;
                    col_next   = sel_col;
                    xc_next    = '0;
                    yc_next    = '0;
                end
            end
            FILL: begin
                vga_x      = ux[7:0];
                vga_y      = uy[6:0];
                vga_colour = col;
                plot       = (ux < XLIM) && (uy < YLIM);
                if (xc == XLAST) begin
                    xc_next = '0;
                    if (yc == YLAST) begin
                        state_next = DONE;
                    end else begin
                        yc_next = yc + 4'd1;
                    end
                end else begin
                    xc_next = xc + 4'd1;
                end
            end
            DONE: begin
                done       = grant_q;
                state_next = IDLE;
                grant_next = '0;
                ptr_next   = (win == 2'd2) ? 2'd0 : win + 2'd1;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_square_plot_arbiter.sv
// Directed bench for square_plot_arbiter: expected pixels are queued per square
// and popped against the DUT pixel port each FILL cycle.
module tb_square_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  grant, done;
    logic        busy, plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    logic [2:0]  req1;
    logic [23:0] req1_x;
    logic [20:0] req1_y;
    logic [8:0]  req1_colour;
    logic [2:0]  grant1, done1;
    logic        busy1, plot1;
    logic [7:0]  vga1_x;
    logic [6:0]  vga1_y;
    logic [2:0]  vga1_colour;

    square_plot_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .grant(grant), .done(done), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
    );

    square_plot_arbiter #(.XDIM(1), .YDIM(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .req_x(req1_x), .req_y(req1_y),
        .req_colour(req1_colour), .grant(grant1), .done(done1), .busy(busy1),
        .vga_x(vga1_x), .vga_y(vga1_y), .vga_colour(vga1_colour), .plot(plot1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       p;
    } px_t;

    px_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_square(input int ox, input int oy);
        for (int yy = 0; yy < 10; yy++) begin
            for (int xx = 0; xx < 10; xx++) begin
                px_t e;
                int  ax, ay;
                ax  = ox + xx;
                ay  = oy + yy;
                e.x = 8'(ax % 256);
                e.y = 7'(ay % 128);
                e.p = (ax < 160) && (ay < 120);
                sb.push_back(e);
            end
        end
    endtask

    // Entered at the falling edge of the first FILL cycle; leaves at the
    // falling edge of the IDLE cycle that follows DONE.
    task automatic check_square(input logic [2:0] g, input logic [2:0] col,
                                input logic [2:0] req_done, input int abort_at,
                                input int drop_at, output int nplot);
        nplot = 0;
        for (int i = 0; i < 100; i++) begin
            px_t e;
            e = sb.pop_front();
            chk("grant_fill", grant, g);
            chk("vga_x", vga_x, e.x);
            chk("vga_y", vga_y, e.y);
            chk("plot", plot, e.p);
            chk("colour", vga_colour, col);
            chk("done_fill", done, 0);
            chk("busy_fill", busy, 1);
            if (plot === 1'b1) nplot++;
            if (i == drop_at) begin
                req               = '0;
                req_x[15:8]       = 8'hAA;
                req_y[13:7]       = 7'h55;
                req_colour[5:3]   = 3'b111;
            end
            if (i + 1 == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_plot", plot, 0);
                chk("abort_grant", grant, 0);
                chk("abort_done", done, 0);
                chk("abort_vga_x", vga_x, 0);
                chk("abort_vga_y", vga_y, 0);
                sb.delete();
                return;
            end
            @(negedge clk);
        end
        chk("done_pulse", done, g);
        chk("grant_done", grant, g);
        chk("plot_done", plot, 0);
        chk("busy_done", busy, 1);
        chk("vga_x_done", vga_x, 0);
        req = req_done;
        @(negedge clk);
        chk("grant_idle", grant, 0);
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("plot_idle", plot, 0);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        req         = '0;
        req_x       = {8'd155, 8'd60, 8'd30};
        req_y       = {7'd115, 7'd20, 7'd30};
        req_colour  = {3'b110, 3'b011, 3'b100};
        req1        = '0;
        req1_x      = {8'd0, 8'd5, 8'd0};
        req1_y      = {7'd0, 7'd6, 7'd0};
        req1_colour = {3'b000, 3'b101, 3'b000};

        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_plot", plot, 0);
        chk("rst_done", done, 0);
        chk("rst_vga_x", vga_x, 0);

        // Request while reset is held must not be granted.
        req = 3'b111;
        @(negedge clk);
        chk("rst_hold_grant", grant, 0);
        chk("rst_hold_busy", busy, 0);

        // All three held: rotation 001, 010, 100, 001.
        reset = 1'b0;
        push_square(30, 30);
        @(negedge clk);
        check_square(3'b001, 3'b100, 3'b111, -1, -1, n);
        push_square(60, 20);
        @(negedge clk);
        check_square(3'b010, 3'b011, 3'b111, -1, -1, n);
        push_square(155, 115);
        @(negedge clk);
        check_square(3'b100, 3'b110, 3'b111, -1, -1, n);
        chk("rr_edge_pixels", n, 25);
        push_square(30, 30);
        @(negedge clk);
        check_square(3'b001, 3'b100, 3'b000, -1, -1, n);

        // Single requester 0 at (30,30).
        req = 3'b001;
        push_square(30, 30);
        @(negedge clk);
        check_square(3'b001, 3'b100, 3'b000, -1, -1, n);
        chk("basic_pixels", n, 100);

        // Bottom-right clipping at (155,115).
        req = 3'b100;
        push_square(155, 115);
        @(negedge clk);
        check_square(3'b100, 3'b110, 3'b000, -1, -1, n);
        chk("edge_pixels", n, 25);

        // Owner drops req and changes its inputs mid-FILL.
        req = 3'b010;
        push_square(60, 20);
        @(negedge clk);
        check_square(3'b010, 3'b011, 3'b000, -1, 50, n);
        req_x[15:8]     = 8'd60;
        req_y[13:7]     = 7'd20;
        req_colour[5:3] = 3'b011;

        // ptr is now 2; reset mid-FILL must abandon the square and clear ptr.
        req = 3'b111;
        push_square(155, 115);
        @(negedge clk);
        check_square(3'b100, 3'b110, 3'b000, 40, -1, n);
        reset = 1'b0;
        req   = 3'b101;
        push_square(30, 30);
        @(negedge clk);
        check_square(3'b001, 3'b100, 3'b000, -1, -1, n);

        // 1x1 square on the second instance.
        req1 = 3'b010;
        @(negedge clk);
        chk("u1_grant", grant1, 3'b010);
        chk("u1_plot", plot1, 1);
        chk("u1_x", vga1_x, 5);
        chk("u1_y", vga1_y, 6);
        chk("u1_colour", vga1_colour, 3'b101);
        chk("u1_done_fill", done1, 0);
        @(negedge clk);
        chk("u1_done", done1, 3'b010);
        chk("u1_plot_done", plot1, 0);
        chk("u1_grant_done", grant1, 3'b010);
        req1 = '0;
        @(negedge clk);
        chk("u1_grant_idle", grant1, 0);
        chk("u1_busy_idle", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/square_plot_arbiter.md
SQUARE_PLOT_ARBITER -- requirements
Module: square_plot_arbiter

Interface
REQ-001 Parameter XDIM, default 10, square width in pixels (1..16).
REQ-002 Parameter YDIM, default 10, square height in pixels (1..16).
REQ-003 Parameter XSCREEN, default 160, visible width; YSCREEN, default 120, visible height.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  per-requester draw request (bit0 apple, bit1 snake draw, bit2 snake erase), level, held until matching done.
REQ-007 req_x  input  24  three packed 8-bit square origin X values, requester i at [8i+7:8i].
REQ-008 req_y  input  21  three packed 7-bit square origin Y values, requester i at [7i+6:7i].
REQ-009 req_colour  input  9  three packed 3-bit colours, requester i at [3i+2:3i].
REQ-010 grant  output  3  one-hot owner of the plot port; zero when idle.
REQ-011 done  output  3  one-cycle pulse to the owning requester when its square completes.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 vga_x  output  8; vga_y  output  7; vga_colour  output  3; plot  output  1; direct to the VGA adapter pixel port.

Function
REQ-014 States: IDLE, FILL, DONE; 2-bit encoding; no other reachable states.
REQ-015 IDLE: if req is zero, remain in IDLE; else select winner, latch its x/y/colour, set grant one-hot, clear xc/yc, go to FILL next edge.
REQ-016 Selection is round-robin: search order starts at pointer ptr (0..2) and wraps 2->0; first set req bit wins.
REQ-017 ptr resets to 0; on leaving DONE, ptr = (winner+1) mod 3.
REQ-018 Latched origin/colour are frozen for the whole FILL; changes on req_x/req_y/req_colour during FILL have no effect.
REQ-019 FILL: vga_x = X0+xc (8-bit, wraps mod 256), vga_y = Y0+yc (7-bit, wraps mod 128), vga_colour = latched colour.
REQ-020 FILL: xc increments every cycle; at xc==XDIM-1, xc->0 and yc increments; at xc==XDIM-1 and yc==YDIM-1, go to DONE.
REQ-021 FILL lasts exactly XDIM*YDIM cycles, raster order, row-major, top-left first.
REQ-022 plot = 1 in FILL only when X0+xc (9-bit unwrapped) < XSCREEN and Y0+yc (8-bit unwrapped) < YSCREEN; off-screen pixels are skipped but still consume their cycle.
REQ-023 DONE: one cycle; done[winner]=1, plot=0, grant still set; next edge grant->0, state->IDLE.
REQ-024 Deassertion of the owner's req during FILL is ignored; the square always completes and done still pulses.
REQ-025 Requests arriving during FILL/DONE wait; earliest re-grant is the edge after the IDLE cycle following DONE (two dead cycles between squares).
REQ-026 Outside FILL: plot=0, vga_x/vga_y/vga_colour = 0.
REQ-027 grant and done are never multi-hot; done never asserts outside DONE.

Reset
REQ-028 reset high at any edge, including mid-FILL: next state IDLE, ptr=0, xc=yc=0, latched origin/colour=0, grant=0, done=0, busy=0, plot=0, vga outputs 0.
REQ-029 An interrupted square is abandoned; no done pulse is issued for it.
REQ-030 First grant after reset deasserts requires reset low at the sampling edge in IDLE.

Verification
REQ-031 req=001, origin (30,30), colour 100, XDIM=YDIM=10 -> grant=001 next cycle; 100 plot cycles (30,30)..(39,39) row-major; done=001 on cycle 101.
REQ-032 req=111 held, ptr=0 -> grants in order 001, 010, 100, 001; each separated by DONE+IDLE cycles.
REQ-033 Origin (155,115), 10x10 -> 100 FILL cycles, plot high only for x 155..159 and y 115..119 (25 pixels).
REQ-034 Owner drops req and changes req_x mid-FILL -> pixel addresses unchanged, done still pulses at cycle 101.
REQ-035 reset asserted at FILL cycle 40 -> next cycle busy=0, plot=0, grant=0, no done; following request granted from ptr=0.
REQ-036 XDIM=YDIM=1, req=010 -> single plot cycle, done=010 two cycles after grant sampling edge.
